// File: rtl/pulse_stretch_tx_pkg.sv
// ============================================================================
// Module   : pulse_if_pkg
// Purpose  : Shared types and constants for the async rising-edge pulse link.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } ptx_state_t;

    // Receiver catches pulses with a 2-flop synchronizer plus edge detector.
    localparam int MIN_SYNC_CYCLES = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_stretch_tx_if.sv
// ============================================================================
// Module   : pulse_stretch_tx_if
// Purpose  : Event/status bundle between local logic and pulse_stretch_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pulse_stretch_tx_if #(
    parameter int PEND_W = 4
) ();

    logic              evt_in;
    logic              clr_ovf;
    logic              pulse_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output evt_in,
        output clr_ovf,
        input  pulse_out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  evt_in,
        input  clr_ovf,
        output pulse_out,
        output busy,
        output pending,
        output overflow
    );

endinterface

`default_nettype wire

// File: rtl/pulse_stretch_tx_pend_cnt.sv
// ============================================================================
// Module   : ptx_pend_cnt
// Purpose  : Saturating up/down pending-event counter with sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ptx_pend_cnt #(
    parameter int PEND_W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_inc,
    input  wire logic              i_dec,
    input  wire logic              i_clr_ovf,
    output logic      [PEND_W-1:0] o_count,
    output logic                   o_ovf
);

    localparam logic [PEND_W-1:0] C_MAX = {PEND_W{1'b1}};

    logic [PEND_W-1:0] count_q, count_d;
    logic              ovf_q,   ovf_d;
    logic              w_ovf_set;

    always_comb begin
        count_d   = count_q;
        w_ovf_set = 1'b0;
        if (i_inc && !i_dec) begin
            if (count_q == C_MAX) begin
                w_ovf_set = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (i_dec && !i_inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
        // A new overflow outranks a clear arriving in the same cycle.
        ovf_d = w_ovf_set | (ovf_q & ~i_clr_ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_count = count_q;
    assign o_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/pulse_stretch_tx.sv
// ============================================================================
// Module   : pulse_stretch_tx
// Purpose  : Stretches event strobes into spaced, registered level pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_stretch_tx
    import pulse_if_pkg::*;
#(
    parameter int HIGH_CYCLES = 3,
    parameter int LOW_CYCLES  = 3,
    parameter int PEND_W      = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pulse_stretch_tx_if.slave bus
);

    localparam int C_TMAX = max_int(HIGH_CYCLES, LOW_CYCLES);
    localparam int C_TW   = (C_TMAX > 1) ? $clog2(C_TMAX) : 1;

    if (HIGH_CYCLES < MIN_SYNC_CYCLES) begin : g_chk_high
        $error("HIGH_CYCLES too small for the receiver synchronizer");
    end
    if (LOW_CYCLES < MIN_SYNC_CYCLES) begin : g_chk_low
        $error("LOW_CYCLES too small for the receiver synchronizer");
    end
    if (PEND_W < 1) begin : g_chk_pend
        $error("PEND_W must be at least 1");
    end
    if ($bits(bus.pending) != PEND_W) begin : g_chk_if
        $error("interface PEND_W does not match module PEND_W");
    end

    ptx_state_t        state_q, state_d;
    logic [C_TW-1:0]   timer_q, timer_d;
    logic              pulse_out_q, pulse_out_d;

    logic [PEND_W-1:0] w_pending;
    logic              w_overflow;
    logic              w_pend_nz;
    logic              w_exit_low;
    logic              w_can_start;
    logic              w_start;
    logic              w_inc;
    logic              w_dec;

    assign w_pend_nz   = (w_pending != '0);
    assign w_exit_low  = (state_q == LOW) && (timer_q == C_TW'(LOW_CYCLES - 1));
    assign w_can_start = (state_q == IDLE) || w_exit_low;
    assign w_start     = w_can_start && (bus.evt_in || w_pend_nz);
    // Queued events go first; an event only bypasses the queue when it is empty.
    assign w_dec       = w_can_start && w_pend_nz;
    assign w_inc       = bus.evt_in && !(w_can_start && !w_pend_nz);

    ptx_pend_cnt #(
        .PEND_W (PEND_W)
    ) u_pend_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (w_inc),
        .i_dec     (w_dec),
        .i_clr_ovf (bus.clr_ovf),
        .o_count   (w_pending),
        .o_ovf     (w_overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            pulse_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pulse_out_q <= pulse_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (w_start) begin
                    state_d = HIGH;
                    timer_d = '0;
                end
            end
            HIGH: begin
                if (timer_q == C_TW'(HIGH_CYCLES - 1)) begin
                    state_d = LOW;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + C_TW'(1);
                end
            end
            LOW: begin
                if (w_exit_low) begin
                    state_d = w_start ? HIGH : IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + C_TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Registered from the next state so pulse_out has no path from evt_in.
    always_comb begin
        pulse_out_d = (state_d == HIGH);
    end

    assign bus.pulse_out = pulse_out_q;
    assign bus.busy      = (state_q != IDLE) || w_pend_nz;
    assign bus.pending   = w_pending;
    assign bus.overflow  = w_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretch_tx.sv
// ============================================================================
// Module   : tb_pulse_stretch_tx
// Purpose  : Directed self-checking bench for pulse_stretch_tx with loopback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_stretch_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pulse_stretch_tx_if #(.PEND_W(4)) bus ();

    pulse_stretch_tx #(
        .HIGH_CYCLES (3),
        .LOW_CYCLES  (3),
        .PEND_W      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transmit-side monitor: rise count and pulse-shape violations.
    int   tx_rises = 0;
    int   shape_err = 0;
    int   hi_run = 0;
    int   lo_run = 10;
    logic prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (bus.pulse_out) begin
            if (!prev_pulse) begin
                tx_rises = tx_rises + 1;
                if (lo_run < 3) shape_err = shape_err + 1;
                hi_run = 0;
            end
            hi_run = hi_run + 1;
        end else begin
            if (prev_pulse) begin
                if (hi_run != 3) shape_err = shape_err + 1;
                lo_run = 0;
            end
            lo_run = lo_run + 1;
        end
        prev_pulse = bus.pulse_out;
    end

    // Receiver model: 2-flop synchronizer plus rising-edge detector.
    logic rx_s1 = 1'b0, rx_s2 = 1'b0, rx_s3 = 1'b0;
    int   rx_rises = 0;

    always @(posedge clk) begin
        rx_s1 <= bus.pulse_out;
        rx_s2 <= rx_s1;
        rx_s3 <= rx_s2;
        if (rx_s2 && !rx_s3) rx_rises <= rx_rises + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (bus.busy && n < max_cycles) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    int base_tx, base_rx, base_shape, n_evt, peak;
    logic pend_pulse;

    initial begin
        bus.evt_in  = 1'b0;
        bus.clr_ovf = 1'b0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pulse", {31'd0, bus.pulse_out}, 32'd0);
        chk("rst_busy",  {31'd0, bus.busy},      32'd0);
        chk("rst_pend",  {28'd0, bus.pending},   32'd0);
        chk("rst_ovf",   {31'd0, bus.overflow},  32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Single event: high cycles 1..3, low 4..6, idle at 7.
        base_tx = tx_rises;
        for (int c = 0; c <= 7; c++) begin
            tick();
            bus.evt_in = (c == 0);
            chk($sformatf("single_pulse_c%0d", c), {31'd0, bus.pulse_out},
                {31'd0, (c >= 1 && c <= 3)});
            chk($sformatf("single_busy_c%0d", c), {31'd0, bus.busy},
                {31'd0, (c >= 1 && c <= 6)});
            chk($sformatf("single_pend_c%0d", c), {28'd0, bus.pending}, 32'd0);
        end
        chk("single_rises", tx_rises - base_tx, 32'd1);

        // Burst of three: rises at 1, 7, 13.
        base_tx = tx_rises;
        for (int c = 0; c <= 19; c++) begin
            tick();
            bus.evt_in = (c < 3);
            pend_pulse = (c >= 1 && c <= 3) || (c >= 7 && c <= 9) || (c >= 13 && c <= 15);
            chk($sformatf("burst_pulse_c%0d", c), {31'd0, bus.pulse_out}, {31'd0, pend_pulse});
            if (c == 3)  chk("burst_pend_c3",  {28'd0, bus.pending}, 32'd2);
            if (c == 9)  chk("burst_pend_c9",  {28'd0, bus.pending}, 32'd1);
            if (c == 13) chk("burst_pend_c13", {28'd0, bus.pending}, 32'd0);
        end
        chk("burst_busy_end", {31'd0, bus.busy}, 32'd0);
        chk("burst_rises", tx_rises - base_tx, 32'd3);

        // Saturation: LOW exits at 6, 12, 18 consume while events keep coming,
        // so 18 of the 19 queued events are accepted and only cycle 19 drops.
        base_tx = tx_rises;
        peak    = 0;
        for (int c = 0; c <= 23; c++) begin
            tick();
            bus.evt_in  = (c < 20) || (c == 21);
            bus.clr_ovf = (c >= 20 && c <= 22);
            if (int'(bus.pending) > peak) peak = int'(bus.pending);
            if (c == 18) chk("sat_pend_c18", {28'd0, bus.pending}, 32'd15);
            if (c == 19) chk("sat_ovf_c19",  {31'd0, bus.overflow}, 32'd0);
            if (c == 20) chk("sat_ovf_c20",  {31'd0, bus.overflow}, 32'd1);
            if (c == 20) chk("sat_pend_c20", {28'd0, bus.pending}, 32'd15);
            if (c == 21) chk("clr_ovf_c21",  {31'd0, bus.overflow}, 32'd0);
            if (c == 22) chk("set_wins_c22", {31'd0, bus.overflow}, 32'd1);
            if (c == 23) chk("clr_ovf_c23",  {31'd0, bus.overflow}, 32'd0);
        end
        bus.evt_in  = 1'b0;
        bus.clr_ovf = 1'b0;
        chk("sat_peak", peak, 32'd15);
        wait_idle(200);
        chk("sat_rises", tx_rises - base_tx, 32'd19);
        chk("sat_pend_end", {28'd0, bus.pending}, 32'd0);

        // Event on the LOW-exit cycle while one is queued.
        base_tx = tx_rises;
        for (int c = 0; c <= 19; c++) begin
            tick();
            bus.evt_in = (c < 2) || (c == 6);
            if (c == 6)  chk("simul_pulse_c6",  {31'd0, bus.pulse_out}, 32'd0);
            if (c == 6)  chk("simul_pend_c6",   {28'd0, bus.pending},   32'd1);
            if (c == 7)  chk("simul_pulse_c7",  {31'd0, bus.pulse_out}, 32'd1);
            if (c == 7)  chk("simul_pend_c7",   {28'd0, bus.pending},   32'd1);
            if (c == 12) chk("simul_pulse_c12", {31'd0, bus.pulse_out}, 32'd0);
            if (c == 13) chk("simul_pulse_c13", {31'd0, bus.pulse_out}, 32'd1);
            if (c == 13) chk("simul_pend_c13",  {28'd0, bus.pending},   32'd0);
        end
        chk("simul_busy_end", {31'd0, bus.busy}, 32'd0);
        chk("simul_rises", tx_rises - base_tx, 32'd3);

        // Reset asserted between edges on the second HIGH cycle.
        for (int c = 0; c <= 2; c++) begin
            tick();
            bus.evt_in = 1'b1;
        end
        chk("mid_pulse_pre", {31'd0, bus.pulse_out}, 32'd1);
        chk("mid_pend_pre",  {28'd0, bus.pending},   32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pulse", {31'd0, bus.pulse_out}, 32'd0);
        chk("mid_rst_pend",  {28'd0, bus.pending},   32'd0);
        chk("mid_rst_ovf",   {31'd0, bus.overflow},  32'd0);
        chk("mid_rst_busy",  {31'd0, bus.busy},      32'd0);
        bus.evt_in = 1'b0;
        #2 rst = 1'b0;
        tick();
        for (int c = 0; c <= 7; c++) begin
            tick();
            bus.evt_in = (c == 0);
            chk($sformatf("post_rst_pulse_c%0d", c), {31'd0, bus.pulse_out},
                {31'd0, (c >= 1 && c <= 3)});
        end

        // Loopback through the receiver model with sparse random events.
        repeat (4) tick();
        base_tx    = tx_rises;
        base_rx    = rx_rises;
        base_shape = shape_err;
        n_evt      = 0;
        for (int c = 0; c < 600; c++) begin
            tick();
            bus.evt_in = ($urandom_range(0, 7) == 0);
            if (bus.evt_in) n_evt++;
        end
        bus.evt_in = 1'b0;
        wait_idle(300);
        repeat (4) tick();
        chk("loop_ovf", {31'd0, bus.overflow}, 32'd0);
        chk("loop_tx_vs_evt", tx_rises - base_tx, n_evt);
        chk("loop_rx_vs_tx", rx_rises - base_rx, tx_rises - base_tx);
        chk("loop_shape", shape_err - base_shape, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
